// File: rtl/div_issue_ctrl.sv
// Operand FIFO and issue sequencer for the iterative fractional divider.
// Optional divide-by-zero bypass: define DIVZERO_CHK_EN.
module div_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_y,
    input  logic [7:0] in_x,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_q,
    output logic [7:0] out_r,
    output logic       out_err,
    output logic       busy,
    output logic [7:0] div_y,
    output logic [7:0] div_x,
    output logic       div_start,
    input  logic       div_ready,
    input  logic [7:0] div_q,
    input  logic [7:0] div_r
);

    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACK,
`ifdef DIVZERO_CHK_EN
        ZERO,
`endif
        RUN
    } state_t;

    state_t state, state_nx;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   head;
    logic [7:0]    op_y, op_x;
    logic          push, pop, cap, slot_free;
`ifdef DIVZERO_CHK_EN
    logic          zcap;
    logic          err_r;
`endif

    assign in_ready  = (count != FULL);
    assign push      = in_valid && in_ready;
    assign head      = mem[rd_ptr];
    assign slot_free = !out_valid || out_ready;
    assign div_y     = op_y;
    assign div_x     = op_x;
    assign div_start = (state == ISSUE);
    assign busy      = (count != '0) || (state != IDLE);

`ifdef DIVZERO_CHK_EN
    assign out_err = err_r;
`else
    assign out_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        cap      = 1'b0;
`ifdef DIVZERO_CHK_EN
        zcap     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
`ifdef DIVZERO_CHK_EN
                    if (head[7:0] == 8'h00)
                        state_nx = ZERO;
`endif
                end
            end
            ISSUE: if (div_ready) state_nx = ACK;
            // ready must drop first, else a stale ready looks like done
            ACK: if (!div_ready) state_nx = RUN;
            RUN: begin
                if (div_ready && slot_free) begin
                    cap      = 1'b1;
                    state_nx = IDLE;
                end
            end
`ifdef DIVZERO_CHK_EN
            ZERO: begin
                if (slot_free) begin
                    zcap     = 1'b1;
                    state_nx = IDLE;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_y, in_x};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            op_y   <= '0;
            op_x   <= '0;
        end else begin
            state <= state_nx;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                op_y   <= head[15:8];
                op_x   <= head[7:0];
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
`ifdef DIVZERO_CHK_EN
            err_r     <= 1'b0;
`endif
        end else if (cap) begin
            out_valid <= 1'b1;
            out_q     <= div_q;
            out_r     <= div_r;
`ifdef DIVZERO_CHK_EN
            err_r     <= 1'b0;
        end else if (zcap) begin
            out_valid <= 1'b1;
            out_q     <= 8'hFF;
            out_r     <= op_y;
            err_r     <= 1'b1;
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a cycle-level divider model.
// Results are checked against a queue of arithmetically computed quotients.
module tb_div_issue_ctrl;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_y;
    logic [7:0] in_x;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_q;
    logic [7:0] out_r;
    logic       out_err;
    logic       busy;
    logic [7:0] div_y;
    logic [7:0] div_x;
    logic       div_start;
    logic       div_ready;
    logic [7:0] div_q;
    logic [7:0] div_r;

    div_issue_ctrl #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_err(out_err),
        .busy(busy),
        .div_y(div_y), .div_x(div_x),
        .div_start(div_start), .div_ready(div_ready),
        .div_q(div_q), .div_r(div_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       err;
    } res_t;

    function automatic res_t model(input logic [7:0] y, input logic [7:0] x);
        res_t e;
        int   n;
        n = int'(y) * 256;
        if (x == 8'h00) begin
            e.q = 8'hFF;
            e.r = y;
`ifdef DIVZERO_CHK_EN
            e.err = 1'b1;
`else
            e.err = 1'b0;
`endif
        end else begin
            e.q   = 8'(n / int'(x));
            e.r   = 8'(n % int'(x));
            e.err = 1'b0;
        end
        return e;
    endfunction

    // Divider: ready drops on start, q/r appear 25 edges later and are held
    logic [7:0] dv_y, dv_x;
    int         dv_cnt;
    always @(posedge clk) begin
        if (reset) begin
            div_ready <= 1'b1;
            div_q     <= 8'h00;
            div_r     <= 8'h00;
            dv_cnt    <= 0;
            dv_y      <= 8'h00;
            dv_x      <= 8'h00;
        end else if (div_ready && div_start) begin
            div_ready <= 1'b0;
            dv_cnt    <= 25;
            dv_y      <= div_y;
            dv_x      <= div_x;
        end else if (dv_cnt > 0) begin
            dv_cnt <= dv_cnt - 1;
            if (dv_cnt == 1) begin
                div_ready <= 1'b1;
                if (dv_x == 8'h00) begin
                    div_q <= 8'hFF;
                    div_r <= dv_y;
                end else begin
                    div_q <= 8'((int'(dv_y) * 256) / int'(dv_x));
                    div_r <= 8'((int'(dv_y) * 256) % int'(dv_x));
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    res_t       exp_q[$];
    int         starts = 0;
    int         rise_cyc = 0;
    logic [7:0] last_q, last_r;
    logic       last_err;
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pq, prr;

    always @(negedge clk) begin
        res_t e;
        if (reset) begin
            exp_q.delete();
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (div_start) starts++;
            if (out_valid && !pv) rise_cyc = cyc;
            if (pv && !pr) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_q", 32'(out_q), 32'(pq));
                chk("hold_r", 32'(out_r), 32'(prr));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got q=%0h r=%0h expected none",
                             out_q, out_r);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_q", 32'(out_q), 32'(e.q));
                    chk("res_r", 32'(out_r), 32'(e.r));
                    chk("res_err", 32'(out_err), 32'(e.err));
                    last_q   = out_q;
                    last_r   = out_r;
                    last_err = out_err;
                end
            end
            pv  = out_valid;
            pr  = out_ready;
            pq  = out_q;
            prr = out_r;
        end
    end

    int acc_cyc = 0;

    task automatic push(input logic [7:0] y, input logic [7:0] x);
        int n;
        in_y     = y;
        in_x     = x;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            exp_q.push_back(model(y, x));
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0)
            chk("result_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    int s0;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_y      = 8'h00;
        in_x      = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        @(posedge clk);
        #1;

        s0 = starts;
        push(8'd1, 8'd2);
        wait_done();
        chk("op1_latency", 32'(rise_cyc - acc_cyc), 32'd28);
        chk("op1_starts", 32'(starts - s0), 32'd1);
        chk("op1_q", 32'(last_q), 32'h80);
        chk("op1_r", 32'(last_r), 32'h00);
        chk("op1_busy", 32'(busy), 32'd0);

        s0 = starts;
        push(8'd1, 8'd3);
        wait_done();
        chk("op2_latency", 32'(rise_cyc - acc_cyc), 32'd28);
        chk("op2_starts", 32'(starts - s0), 32'd1);
        chk("op2_q", 32'(last_q), 32'h55);
        chk("op2_r", 32'(last_r), 32'h01);

        out_ready = 1'b0;
        s0 = starts;
        push(8'd1, 8'd2);
        push(8'd1, 8'd3);
        push(8'd7, 8'd9);
        push(8'h10, 8'h11);
        push(8'h40, 8'hC0);
        @(negedge clk);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_busy", 32'(busy), 32'd1);
        repeat (70) @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_q", 32'(out_q), 32'h80);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("overlap_valid", 32'(out_valid), 32'd1);
        chk("overlap_q", 32'(out_q), 32'h55);
        chk("overlap_r", 32'(out_r), 32'h01);
        @(posedge clk);
        #1;
        wait_done();
        chk("fill_starts", 32'(starts - s0), 32'd5);
        chk("fill_last_q", 32'(last_q), 32'h55);
        chk("fill_last_r", 32'(last_r), 32'h40);

        s0 = starts;
        push(8'h05, 8'h00);
        wait_done();
`ifdef DIVZERO_CHK_EN
        chk("zero_starts", 32'(starts - s0), 32'd0);
        chk("zero_latency", 32'(rise_cyc - acc_cyc), 32'd2);
        chk("zero_q", 32'(last_q), 32'hFF);
        chk("zero_r", 32'(last_r), 32'h05);
        chk("zero_err", 32'(last_err), 32'd1);
`else
        chk("zero_starts", 32'(starts - s0), 32'd1);
        chk("zero_err", 32'(last_err), 32'd0);
`endif

        push(8'd3, 8'd4);
        push(8'd2, 8'd5);
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_q", 32'(out_q), 32'd0);
        chk("mid_rst_out_r", 32'(out_r), 32'd0);
        chk("mid_rst_div_start", 32'(div_start), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_div_y", 32'(div_y), 32'd0);
        @(posedge clk);
        #1;

        push(8'd3, 8'd4);
        wait_done();
        chk("post_rst_latency", 32'(rise_cyc - acc_cyc), 32'd28);
        chk("post_rst_q", 32'(last_q), 32'hC0);
        chk("post_rst_r", 32'(last_r), 32'h00);
        repeat (40) @(posedge clk);
        #1;
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
